// File: rtl/sipo4.sv
// Serial-in parallel-out shift register with selectable shift direction.
// resetn is active-high and synchronous despite its name.
module sipo4 #(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             data_in,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;

  // MSB_FIRST=1 enters at bit 0 and ages upward; MSB_FIRST=0 enters at the top and ages downward.
  always_comb begin
    q_d = q_q;
    if (MSB_FIRST) begin
      q_d = {q_q[WIDTH-2:0], data_in};
    end else begin
      q_d = {data_in, q_q[WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk) begin
    if (resetn) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: tb/tb_sipo4.sv
// Directed bench for sipo4: one MSB-first and one LSB-first instance share clock and reset.
module tb_sipo4;

  logic       clk;
  logic       resetn;
  logic       data_in;
  logic       data_in_lsb;
  logic [3:0] q;
  logic [3:0] q_lsb;

  int n_total;
  int n_bad;

  sipo4 #(.WIDTH(4), .MSB_FIRST(1'b1)) dut (
    .clk     (clk),
    .resetn  (resetn),
    .data_in (data_in),
    .q       (q)
  );

  sipo4 #(.WIDTH(4), .MSB_FIRST(1'b0)) dut_lsb (
    .clk     (clk),
    .resetn  (resetn),
    .data_in (data_in_lsb),
    .q       (q_lsb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Apply inputs, take one rising edge, then settle just past it for sampling.
  task automatic step(input logic r, input logic d, input logic d_lsb);
    resetn      = r;
    data_in     = d;
    data_in_lsb = d_lsb;
    @(posedge clk);
    #1;
  endtask

  logic [3:0] fill_exp [10];
  logic       fill_dat [10];
  logic [3:0] lsb_exp  [4];
  logic       lsb_dat  [4];

  initial begin
    n_total = 0;
    n_bad   = 0;
    resetn      = 1'b1;
    data_in     = 1'b1;
    data_in_lsb = 1'b1;

    fill_dat = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    fill_exp = '{4'b0001, 4'b0011, 4'b0110, 4'b1101,
                 4'b1010, 4'b0100, 4'b1001, 4'b0011, 4'b0110, 4'b1100};
    lsb_dat  = '{1'b1, 1'b0, 1'b0, 1'b0};
    lsb_exp  = '{4'b1000, 4'b0100, 4'b0010, 4'b0001};

    @(negedge clk);

    // Reset held for two edges with data_in high.
    for (int i = 0; i < 2; i++) begin
      step(1'b1, 1'b1, 1'b1);
      check($sformatf("rst_msb_%0d", i), {28'd0, q}, 32'h0);
      check($sformatf("rst_lsb_%0d", i), {28'd0, q_lsb}, 32'h0);
    end

    // Fill and continue streaming; the LSB-first instance runs its own pattern alongside.
    for (int i = 0; i < 10; i++) begin
      step(1'b0, fill_dat[i], (i < 4) ? lsb_dat[i] : 1'b0);
      check($sformatf("fill_%0d", i), {28'd0, q}, {28'd0, fill_exp[i]});
      if (i < 4) begin
        check($sformatf("lsb_%0d", i), {28'd0, q_lsb}, {28'd0, lsb_exp[i]});
      end
    end

    // Bring q back to 1101 from 1100.
    step(1'b0, 1'b1, 1'b0);
    check("refill_0", {28'd0, q}, 32'h9);
    step(1'b0, 1'b1, 1'b0);
    check("refill_1", {28'd0, q}, 32'h3);
    step(1'b0, 1'b0, 1'b0);
    check("refill_2", {28'd0, q}, 32'h6);
    step(1'b0, 1'b1, 1'b0);
    check("refill_3", {28'd0, q}, 32'hD);

    // Mid-stream reset wins over data_in, then the next edge shifts into zero.
    step(1'b1, 1'b1, 1'b1);
    check("mid_rst", {28'd0, q}, 32'h0);
    check("mid_rst_lsb", {28'd0, q_lsb}, 32'h0);
    step(1'b0, 1'b1, 1'b1);
    check("post_rst", {28'd0, q}, 32'h1);
    check("post_rst_lsb", {28'd0, q_lsb}, 32'h8);

    // Between-edge glitches on data_in and resetn must not disturb q.
    resetn  = 1'b0;
    data_in = 1'b0;
    data_in_lsb = 1'b0;
    #1;
    resetn  = 1'b1;
    data_in = 1'b1;
    data_in_lsb = 1'b1;
    #1;
    check("glitch_hi", {28'd0, q}, 32'h1);
    check("glitch_hi_lsb", {28'd0, q_lsb}, 32'h8);
    resetn  = 1'b0;
    data_in = 1'b0;
    data_in_lsb = 1'b0;
    #1;
    check("glitch_lo", {28'd0, q}, 32'h1);
    @(posedge clk);
    #1;
    check("glitch_edge", {28'd0, q}, 32'h2);
    check("glitch_edge_lsb", {28'd0, q_lsb}, 32'h4);

    // A single 1 reaches the far end after WIDTH-1 more edges and drops off at WIDTH.
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    check("lat_entry", {28'd0, q}, 32'h1);
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    check("lat_far", {28'd0, q}, 32'h8);
    step(1'b0, 1'b0, 1'b0);
    check("lat_gone", {28'd0, q}, 32'h0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/sipo4.md
SIPO4 -- requirements
Module: sipo4

Interface
REQ-001 Parameter: WIDTH, default 4, meaning parallel output width in bits; legal range 2..32.
REQ-002 Parameter: MSB_FIRST, default 1, meaning serial bit ordering.
- 1: new bit enters q[0], older bits move toward q[WIDTH-1].
- 0: new bit enters q[WIDTH-1], older bits move toward q[0].
REQ-003 Port: clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 Port: resetn  input  1  reset, synchronous and active-high; asserted when 1, sampled only on the rising edge of clk.
REQ-005 Port: data_in  input  1  serial data bit, sampled on the rising edge of clk.
REQ-006 Port: q  output  WIDTH  parallel register contents, driven directly from flip-flops with no combinational path from any input.
REQ-007 No other ports; one clock domain only.

Function
REQ-008 The block SHALL be a WIDTH-bit serial-in parallel-out shift register.
REQ-009 With MSB_FIRST=1, each rising edge with resetn=0 SHALL load q <= {q[WIDTH-2:0], data_in}.
REQ-010 With MSB_FIRST=0, each rising edge with resetn=0 SHALL load q <= {data_in, q[WIDTH-1:1]}.
REQ-011 A shift SHALL occur on every clock edge while reset is deasserted; there is no enable and no hold state.
REQ-012 Latency: a bit sampled at edge N SHALL appear at its entry position after edge N.
- It SHALL reach the far end (q[WIDTH-1] for MSB_FIRST=1) after edge N+WIDTH-1.
- It SHALL be discarded at edge N+WIDTH.
REQ-013 After WIDTH consecutive shifts with no reset, q SHALL equal the last WIDTH sampled bits; with MSB_FIRST=1 the oldest bit is in q[WIDTH-1].
REQ-014 q SHALL change only at rising edges of clk; changes of data_in or resetn between edges SHALL have no effect on q.
REQ-015 data_in equal to X/Z is outside the contract; q behaviour is then unspecified.

Reset
REQ-016 When resetn=1 at a rising edge, q SHALL become all zeros at that edge.
REQ-017 Reset SHALL take priority over shifting; data_in is ignored on a reset edge.
REQ-018 Reset applied mid-stream SHALL discard all previously shifted bits.
REQ-019 The first edge with resetn=0 SHALL shift normally into the zeroed register.
REQ-020 Before the first reset edge q is undefined; no power-on value is guaranteed.

Verification
REQ-021 Reset: resetn=1 for 2 edges with data_in=1 -> q=4'b0000 after each edge.
REQ-022 Fill (MSB_FIRST=1): after reset, shift data_in sequence 1,1,0,1 on 4 edges -> q after each edge = 0001, 0011, 0110, 1101.
REQ-023 Continue from REQ-022 with sequence 0,0,1,1,0,0 -> q = 1010, 0100, 1001, 0011, 0110, 1100.
REQ-024 Mid-stream reset: q=4'b1101, assert resetn=1 for one edge with data_in=1 -> q=0000; next edge with resetn=0, data_in=1 -> q=0001.
REQ-025 Inter-edge glitches: toggle data_in and resetn between edges, restoring them before the edge -> q unchanged, q changes only at edges.
REQ-026 MSB_FIRST=0, WIDTH=4: after reset, shift 1,0,0,0 -> q = 1000, 0100, 0010, 0001.
